// File: rtl/frac_lut6_cfg_loader.sv
// frac_lut6_cfg_loader: bitstream loader and shadow config memory for frac_lut6.
// Optional build macro: FRAC_LUT6_CFG_PARITY_EN (odd-parity check per word).
//
// Ports:
//   prog_clk   in   configuration clock (rising edge)
//   pReset     in   asynchronous active-high reset
//   cfg_start  in   begin a new load (honoured in IDLE only)
//   cfg_data   in   bitstream word, LSB shifted first
//   cfg_par    in   odd-parity bit for cfg_data (parity build only)
//   cfg_valid  in   cfg_data valid
//   cfg_ready  out  loader accepts a word this cycle
//   mem_out    out  committed config {sram[0:63], mode}
//   mem_outb   out  bitwise inverse of mem_out
//   ccff_tail  out  scan chain tail, for the next tile
//   cfg_busy   out  high whenever the loader is not idle
//   cfg_done   out  one-cycle pulse after a commit
//   cfg_err    out  sticky parity error (always 0 without the macro)

module frac_lut6_cfg_loader #(
    parameter int NUM_BITS = 65,
    parameter int WORD_W   = 8,
    parameter int CNT_W    = 7
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                cfg_start,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_par,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [NUM_BITS-1:0] mem_out,
    output logic [NUM_BITS-1:0] mem_outb,
    output logic                ccff_tail,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] mem_q,   mem_d;
    logic [WORD_W-1:0]   word_q,  word_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                done_q,  done_d;
    logic                err_q,   err_d;

    logic accept;
    logic parity_bad;
    logic idx_last;
    logic cnt_last;

    assign accept   = (state_q == ST_LOAD) && cfg_valid;
    assign idx_last = (idx_q == IDX_W'(WORD_W - 1));
    // The shift happening this cycle is the final bit of the whole chain.
    assign cnt_last = (cnt_q == CNT_W'(NUM_BITS - 1));

`ifdef FRAC_LUT6_CFG_PARITY_EN
    assign parity_bad = ~(^{cfg_data, cfg_par});
`else
    logic unused_par;
    assign unused_par = cfg_par;
    assign parity_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // A corrupt word aborts the load; nothing is committed.
                    state_d = parity_bad ? ST_IDLE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_last) begin
                    state_d = ST_COMMIT;
                end else if (idx_last) begin
                    state_d = ST_LOAD;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from the current state
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready = 1'b0;
        cfg_busy  = 1'b1;
        unique case (state_q)
            ST_IDLE:   cfg_busy  = 1'b0;
            ST_LOAD:   cfg_ready = 1'b1;
            ST_SHIFT:  cfg_ready = 1'b0;
            ST_COMMIT: cfg_ready = 1'b0;
            default:   cfg_busy  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        shift_d = shift_q;
        mem_d   = mem_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    word_d = cfg_data;
                    idx_d  = '0;
                    if (parity_bad) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                // Newest bit enters at [0]; the first bit ends at the top.
                shift_d = {shift_q[NUM_BITS-2:0], word_q[idx_q]};
                idx_d   = idx_q + IDX_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_COMMIT: begin
                mem_d  = shift_q;
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            shift_q <= '0;
            mem_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            mem_q   <= mem_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // mem_outb is derived from the same register so the pair can
    // never disagree, including across reset.
    assign mem_out   = mem_q;
    assign mem_outb  = ~mem_q;
    assign ccff_tail = shift_q[NUM_BITS-1];
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Testbench for frac_lut6_cfg_loader: randomized loads against a serial
// bitstream model, plus reset, shadow-hold, partial-word and parity cases.

module tb_frac_lut6_cfg_loader;

    localparam int NB = 65;
    localparam int WW = 8;
    localparam int NW = (NB + WW - 1) / WW;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          cfg_start;
    logic [WW-1:0] cfg_data;
    logic          cfg_par;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [NB-1:0] mem_out;
    logic [NB-1:0] mem_outb;
    logic          ccff_tail;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0] words [NW];
    logic          pars  [NW];
    logic [NB-1:0] hold;
    bit            hold_bad;
    bit            inv_bad;

    frac_lut6_cfg_loader #(
        .NUM_BITS(NB),
        .WORD_W  (WW),
        .CNT_W   (7)
    ) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .cfg_start(cfg_start),
        .cfg_data (cfg_data),
        .cfg_par  (cfg_par),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .mem_out  (mem_out),
        .mem_outb (mem_outb),
        .ccff_tail(ccff_tail),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    // Advance to the next falling edge and watch the shadow memory.
    task automatic tick();
        @(negedge prog_clk);
        if (!cfg_done && mem_out !== hold) hold_bad = 1'b1;
        if (mem_outb !== ~mem_out) inv_bad = 1'b1;
    endtask

    // Serial model: bits leave each word LSB first; the k-th bit of the
    // stream lands at position NB-1-k; anything past NB bits is dropped.
    function automatic logic [NB-1:0] golden();
        bit q[$];
        logic [NB-1:0] e;
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < WW; b++)
                q.push_back(words[w][b]);
        e = '0;
        for (int k = 0; k < NB; k++)
            e[NB-1-k] = q[k];
        return e;
    endfunction

    // Cycles from entering LOAD until cfg_done is visible.
    function automatic int exp_cycles(input int gap);
        int rem;
        int c;
        int n;
        rem = NB;
        c = 0;
        for (int w = 0; w < NW; w++) begin
            n = (rem < WW) ? rem : WW;
            c += gap + 1 + n;
            rem -= n;
        end
        return c + 1;
    endfunction

    task automatic set_words(input logic [WW-1:0] fixed, input bit rnd);
        for (int w = 0; w < NW; w++) begin
            words[w] = rnd ? WW'($urandom) : fixed;
            pars[w]  = ~(^words[w]);
        end
    endtask

    task automatic run_load(input bit do_start, input int gap,
                            input int start_word, input int nsend,
                            input bit want_done,
                            output int cyc, output bit got_done);
        int guard;
        cyc = 0;
        got_done = 1'b0;
        if (do_start) begin
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
        end
        for (int w = 0; w < nsend; w++) begin
            guard = 0;
            while (!cfg_ready && guard < 64) begin
                tick();
                cyc++;
                guard++;
            end
            if (!cfg_ready) begin
                n_tests++;
                n_fail++;
                $display("FAIL ready_timeout word=%0d got ready=0 need 1", w);
                return;
            end
            repeat (gap) begin
                tick();
                cyc++;
            end
            cfg_valid = 1'b1;
            cfg_data  = words[w];
            cfg_par   = pars[w];
            tick();
            cyc++;
            cfg_valid = 1'b0;
            cfg_data  = WW'($urandom);
            cfg_par   = 1'($urandom);
            if (w == start_word) begin
                cfg_start = 1'b1;
                tick();
                cyc++;
                cfg_start = 1'b0;
            end
        end
        if (want_done) begin
            guard = 0;
            while (!cfg_done && guard < 64) begin
                tick();
                cyc++;
                guard++;
            end
            got_done = cfg_done;
        end
    endtask

    task automatic test_reset();
        pReset    = 1'b1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_par   = 1'b0;
        hold      = '0;
        #3;
        n_tests++;
        if (mem_out !== '0 || mem_outb !== '1) begin
            n_fail++;
            $display("FAIL reset_mem got %h/%h need 0/ones", mem_out, mem_outb);
        end
        n_tests++;
        if ({cfg_ready, cfg_busy, cfg_done, cfg_err, ccff_tail} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b need 00000",
                     {cfg_ready, cfg_busy, cfg_done, cfg_err, ccff_tail});
        end
        @(negedge prog_clk);
        pReset = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        int cyc;
        bit got;
        logic [NB-1:0] e;
        set_words(8'hA5, 1'b0);
        e = golden();
        run_load(1'b1, 0, -1, NW, 1'b1, cyc, got);
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL full_done got 0 need 1");
        end
        n_tests++;
        if (cyc != exp_cycles(0)) begin
            n_fail++;
            $display("FAIL full_latency got %0d need %0d", cyc, exp_cycles(0));
        end
        n_tests++;
        if (mem_out !== e || mem_outb !== ~e) begin
            n_fail++;
            $display("FAIL full_mem got %h need %h", mem_out, e);
        end
        n_tests++;
        if (ccff_tail !== e[NB-1]) begin
            n_fail++;
            $display("FAIL full_tail got %b need %b", ccff_tail, e[NB-1]);
        end
        hold = e;
        tick();
        n_tests++;
        if (cfg_done !== 1'b0 || cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pulse got done=%b busy=%b need 0/0",
                     cfg_done, cfg_busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit got;
        logic [NB-1:0] e;
        set_words(8'h00, 1'b1);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = words[0];
        cfg_par   = pars[0];
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        n_tests++;
        if (cfg_busy !== 1'b1 || cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_shifting got busy=%b rdy=%b need 1/0",
                     cfg_busy, cfg_ready);
        end
        #2;
        pReset = 1'b1;
        hold   = '0;
        #1;
        n_tests++;
        if (mem_out !== '0 || mem_outb !== '1) begin
            n_fail++;
            $display("FAIL mid_reset_mem got %h need 0", mem_out);
        end
        n_tests++;
        if ({cfg_ready, cfg_busy, cfg_done, cfg_err, ccff_tail} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ctl got %b need 00000",
                     {cfg_ready, cfg_busy, cfg_done, cfg_err, ccff_tail});
        end
        @(negedge prog_clk);
        pReset = 1'b0;
        tick();
        n_tests++;
        if (cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle got busy=%b need 0", cfg_busy);
        end
        set_words(8'h00, 1'b1);
        e = golden();
        run_load(1'b1, 0, -1, NW, 1'b1, cyc, got);
        n_tests++;
        if (!got || mem_out !== e) begin
            n_fail++;
            $display("FAIL mid_reload got done=%b mem=%h need 1/%h", got, mem_out, e);
        end
        hold = e;
        tick();
    endtask

    task automatic test_shadow_hold();
        int cyc;
        bit got;
        set_words(8'hFF, 1'b0);
        run_load(1'b1, 0, -1, NW, 1'b1, cyc, got);
        n_tests++;
        if (!got || mem_out !== '1) begin
            n_fail++;
            $display("FAIL hold_preload got %h need ones", mem_out);
        end
        hold = '1;
        tick();
        set_words(8'h00, 1'b0);
        hold_bad = 1'b0;
        run_load(1'b1, 3, -1, NW, 1'b1, cyc, got);
        n_tests++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL hold_shadow got early change need ones until done");
        end
        n_tests++;
        if (!got || mem_out !== '0) begin
            n_fail++;
            $display("FAIL hold_commit got %h need 0", mem_out);
        end
        n_tests++;
        if (cyc != exp_cycles(3)) begin
            n_fail++;
            $display("FAIL hold_latency got %0d need %0d", cyc, exp_cycles(3));
        end
        hold = '0;
        tick();
    endtask

    task automatic test_partial_word();
        int cyc;
        bit got;
        logic [NB-1:0] e;
        set_words(8'h00, 1'b1);
        words[NW-1] = 8'hFE;
        pars[NW-1]  = ~(^words[NW-1]);
        e = golden();
        run_load(1'b1, 0, -1, NW, 1'b1, cyc, got);
        n_tests++;
        if (!got || mem_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_bit0 got %b need 0", mem_out[0]);
        end
        n_tests++;
        if (mem_out !== e) begin
            n_fail++;
            $display("FAIL partial_mem got %h need %h", mem_out, e);
        end
        hold = e;
        tick();
    endtask

    task automatic test_ignored_start();
        int cyc;
        bit got;
        logic [NB-1:0] e;
        set_words(8'h00, 1'b1);
        e = golden();
        run_load(1'b1, 0, 3, NW, 1'b1, cyc, got);
        n_tests++;
        if (cyc != exp_cycles(0) || !got) begin
            n_fail++;
            $display("FAIL ign_latency got %0d need %0d", cyc, exp_cycles(0));
        end
        n_tests++;
        if (mem_out !== e) begin
            n_fail++;
            $display("FAIL ign_mem got %h need %h", mem_out, e);
        end
        hold = e;
        tick();
    endtask

    task automatic test_random();
        int cyc;
        int gap;
        bit got;
        logic [NB-1:0] e;
        for (int r = 0; r < 5; r++) begin
            set_words(8'h00, 1'b1);
            gap = $urandom_range(0, 2);
            e = golden();
            run_load(1'b1, gap, -1, NW, 1'b1, cyc, got);
            n_tests++;
            if (!got || mem_out !== e || cyc != exp_cycles(gap)) begin
                n_fail++;
                $display("FAIL rand%0d got %h cyc=%0d need %h cyc=%0d",
                         r, mem_out, cyc, e, exp_cycles(gap));
            end
            hold = e;
            tick();
        end
    endtask

    task automatic test_parity();
        int cyc;
        bit got;
        bit saw;
        logic [NB-1:0] e;
        set_words(8'h00, 1'b1);
        pars[3] = ^words[3];
`ifdef FRAC_LUT6_CFG_PARITY_EN
        hold_bad = 1'b0;
        run_load(1'b1, 0, -1, 4, 1'b0, cyc, got);
        saw = 1'b0;
        repeat (12) begin
            tick();
            if (cfg_done) saw = 1'b1;
        end
        n_tests++;
        if (cfg_err !== 1'b1 || cfg_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL par_err got err=%b busy=%b need 1/0", cfg_err, cfg_busy);
        end
        n_tests++;
        if (saw || hold_bad || mem_out !== hold) begin
            n_fail++;
            $display("FAIL par_nocommit got done=%b mem=%h need 0/%h",
                     saw, mem_out, hold);
        end
        pars[3] = ~(^words[3]);
        e = golden();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_tests++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL par_clear got %b need 0", cfg_err);
        end
        run_load(1'b0, 0, -1, NW, 1'b1, cyc, got);
        n_tests++;
        if (!got || mem_out !== e) begin
            n_fail++;
            $display("FAIL par_reload got %h need %h", mem_out, e);
        end
`else
        e = golden();
        run_load(1'b1, 0, -1, NW, 1'b1, cyc, got);
        n_tests++;
        if (!got || mem_out !== e || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL nopar_load got %h err=%b need %h/0", mem_out, cfg_err, e);
        end
`endif
        hold = e;
        tick();
    endtask

    initial begin
        hold_bad = 1'b0;
        inv_bad  = 1'b0;
        test_reset();
        test_full_load();
        test_reset_mid();
        test_shadow_hold();
        test_partial_word();
        test_ignored_start();
        test_random();
        test_parity();
        n_tests++;
        if (inv_bad) begin
            n_fail++;
            $display("FAIL inverse got mem_outb != ~mem_out need inverse");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got no finish need finish");
        $fatal(1);
    end

endmodule
